// File: rtl/spi_host.sv
// spi_host: mode-0 SPI command transmitter, MSB first, with post-frame hold and inter-frame gap.
// Every output comes straight from a flop; the FSM is split into state register, next-state and output logic.
module spi_host #(
    parameter int CMD_BITS = 4,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic                busy,
    output logic                done,
    output logic                spi_clk,
    output logic                mosi,
    output logic                cs
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = CMD_BITS > 1 ? $clog2(CMD_BITS) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST = BW'(CMD_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [CMD_BITS-1:0] sh_q, sh_d;
    logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
    logic                accept, half_end, last_bit;

    assign accept   = state_q == IDLE && ready_q && cmd_valid;
    assign half_end = cnt_q == '0;
    assign last_bit = bit_q == LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (half_end && sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (half_end) state_d = GAP;
            GAP:     if (half_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt_q counts down each half-period; it is preloaded while idle so the first low half is full length
    always_comb begin
        cnt_d  = half_end ? RELOAD : cnt_q - CW'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_d   = cs_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = RELOAD;
                bit_d = '0;
                if (accept) begin
                    sh_d   = cmd << 1;
                    mosi_d = cmd[CMD_BITS-1];
                    cs_d   = 1'b0;
                    sclk_d = 1'b0;
                end
            end
            SHIFT: begin
                if (half_end && !sclk_q) sclk_d = 1'b1;
                if (half_end && sclk_q) begin
                    sclk_d = 1'b0;
                    if (!last_bit) begin
                        bit_d  = bit_q + BW'(1);
                        mosi_d = sh_q[CMD_BITS-1];
                        sh_d   = sh_q << 1;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign spi_clk   = sclk_q;
    assign mosi      = mosi_q;
    assign cs        = cs_q;
endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed bench; a client-side monitor pops expected commands from a scoreboard queue at each cs rise.
module tb_spi_host;
    localparam int N = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_valid, cmd_ready, busy, done, spi_clk, mosi, cs;
    logic [3:0] cmd;
    logic       valid1, ready1, busy1, done1, sclk1, mosi1, cs1;
    logic [3:0] cmd1;

    spi_host #(.CMD_BITS(4), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .spi_clk(spi_clk), .mosi(mosi), .cs(cs)
    );

    spi_host #(.CMD_BITS(4), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .cmd(cmd1), .cmd_valid(valid1), .cmd_ready(ready1),
        .busy(busy1), .done(done1), .spi_clk(sclk1), .mosi(mosi1), .cs(cs1)
    );

    int         n_assert = 0, n_fail = 0;
    logic [3:0] exp_q[$];
    int         n_push = 0, done_total = 0, low_cnt = 0, nedge = 0, hi_cnt = 0, last_hi = 0;
    logic [3:0] bits = '0;
    logic       pcs = 1'b1, psclk = 1'b0, in_frame = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // client model: shifts mosi in on each spi_clk rise, checks the frame when cs returns high
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst) begin
            in_frame = 1'b0;
            pcs      = 1'b1;
            psclk    = 1'b0;
            hi_cnt   = 0;
        end else begin
            if (cs) chk("sclk_low_while_cs_high", spi_clk, 0);
            if (done) done_total++;
            if (pcs && !cs) begin
                in_frame = 1'b1;
                low_cnt  = 0;
                nedge    = 0;
                bits     = '0;
                last_hi  = hi_cnt;
            end
            if (!cs) begin
                low_cnt++;
                if (spi_clk && !psclk) begin
                    bits = {bits[2:0], mosi};
                    nedge++;
                end
            end
            if (!pcs && cs && in_frame) begin
                in_frame = 1'b0;
                if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("frame_data", bits, e);
                end
                chk("frame_edges", nedge, N);
                chk("cs_low_cycles", low_cnt, (2*N+1)*D);
                chk("done_at_cs_rise", done, 1);
            end
            hi_cnt = cs ? hi_cnt + 1 : 0;
            pcs    = cs;
            psclk  = spi_clk;
        end
    end

    task automatic send(input logic [3:0] c, input bit push);
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", cmd_ready, 1);
        cmd = c;
        cmd_valid = 1'b1;
        if (push) begin
            exp_q.push_back(c);
            n_push++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        int d0 = done_total;
        while (done_total == d0 && k < 200) begin
            @(negedge clk);
            #1 k++;
        end
        chk("done_timeout", done_total != d0, 1);
    endtask

    task automatic latency(input string tag);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cmd_ready && lat < 100);
        chk(tag, lat, (2*N+2)*D+1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, rises, last_rise, lat, low, d0;
        logic p, seen;
        logic [3:0] b1;
        rst = 1'b0; cmd = 4'hA; cmd_valid = 1'b1; cmd1 = '0; valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_cs_div1", cs1, 1);
        // valid is already high as reset releases: the release edge must not start a frame
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);
        chk("no_start_on_release", cs, 1);
        exp_q.push_back(4'hA);
        n_push++;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        latency("latency_A");

        send(4'h5, 1);
        cmd = 4'hF;
        latency("latency_5");

        // back-to-back with valid held high
        cmd = 4'h3; cmd_valid = 1'b1;
        exp_q.push_back(4'h3); n_push++;
        @(posedge clk);
        #1 cmd = 4'hC;
        exp_q.push_back(4'hC); n_push++;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 100);
        chk("b2b_wait", k, (2*N+2)*D+1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("b2b_cs_high", last_hi, D+1);
        wait_done();

        // valid raised during the gap must wait for cmd_ready
        send(4'h2, 1);
        wait_done();
        cmd = 4'hE; cmd_valid = 1'b1;
        exp_q.push_back(4'hE); n_push++;
        chk("ready_low_in_gap", cmd_ready, 0);
        chk("busy_in_gap", busy, 1);
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("gap_len", k, D);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("gap_cs_high", last_hi, D+1);
        wait_done();

        // abort after the second spi_clk rise
        send(4'h6, 0);
        rises = 0; p = 1'b0; k = 0;
        while (rises < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (spi_clk && !p) rises++;
            p = spi_clk;
        end
        chk("abort_two_rises", rises, 2);
        #1 d0 = done_total;
        rst = 1'b0;
        #1;
        chk("abort_cs", cs, 1);
        chk("abort_sclk", spi_clk, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("abort_no_done", done_total, d0);
        send(4'h9, 1);
        wait_done();

        // CLK_DIV=1 instance
        k = 0;
        while (!ready1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmd1 = 4'h7; valid1 = 1'b1;
        @(posedge clk);
        #1 valid1 = 1'b0;
        cmd1 = 4'h0;
        low = 0; rises = 0; last_rise = 0; b1 = '0; p = 1'b0; seen = 1'b0; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!cs1) begin
                low++;
                if (sclk1 && !p) begin
                    b1 = {b1[2:0], mosi1};
                    if (rises > 0) chk("div1_period", lat - last_rise, 2);
                    last_rise = lat;
                    rises++;
                end
            end else if (low > 0 && !seen) begin
                seen = 1'b1;
                chk("div1_done", done1, 1);
            end
            p = sclk1;
        end while (!ready1 && lat < 60);
        chk("div1_data", b1, 4'h7);
        chk("div1_cs_low", low, 9);
        chk("div1_edges", rises, 4);
        chk("div1_latency", lat, 11);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_done", done_total, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
